// File: rtl/link_reset_pattern_gen_if.sv
// link_reset_pattern_gen_if: request, configuration and data bundle for link_reset_pattern_gen
interface link_reset_pattern_gen_if #(
  parameter int WIDTH = 40,
  parameter int FIXED_WIDTH = 32,
  parameter int BURST_W = 8
);
  logic link_reset_slowControl;
  logic link_reset_fastCommand;
  logic [1:0] link_reset_patternMode;
  logic [6:0] link_reset_prbs7Seed;
  logic [FIXED_WIDTH-1:0] link_reset_fixedTestPattern;
  logic [BURST_W-1:0] burstLen;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic linkResetActive;
  logic patternStart;
  modport master (
    output link_reset_slowControl, link_reset_fastCommand, link_reset_patternMode,
           link_reset_prbs7Seed, link_reset_fixedTestPattern, burstLen, din,
    input  dout, linkResetActive, patternStart
  );
  modport slave (
    input  link_reset_slowControl, link_reset_fastCommand, link_reset_patternMode,
           link_reset_prbs7Seed, link_reset_fixedTestPattern, burstLen, din,
    output dout, linkResetActive, patternStart
  );
endinterface

// File: rtl/link_reset_pattern_gen.sv
// link_reset_pattern_gen: link-reset test pattern generator (PRBS7/fixed/alternating, optional counter).
// Counter pattern present only when LINK_RESET_COUNTER_MODE_EN is defined; otherwise mode 10 acts as PRBS7.
module link_reset_pattern_gen #(
  parameter int WIDTH = 40,
  parameter int FIXED_WIDTH = 32,
  parameter int BURST_W = 8
) (
  input logic clk,
  input logic reset,
  link_reset_pattern_gen_if.slave bus
);
  localparam int PH_W = FIXED_WIDTH > 1 ? $clog2(FIXED_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SC, FC} state_t;
  state_t state, stateNext;
  logic sc, fc, entry, emit;
  logic [1:0] mode, curMode;
  logic [6:0] prbs, curPrbs, nxtPrbs, seed;
  logic [PH_W-1:0] phase, curPhase, nxtPhase;
  logic oddWord, curOdd;
  logic [BURST_W-1:0] burstCnt, burstNext;
  logic [WIDTH-1:0] prbsWord, fixedWord, patWord;
`ifdef LINK_RESET_COUNTER_MODE_EN
  logic [WIDTH-1:0] wordCnt, curCnt;
`endif
  assign sc = bus.link_reset_slowControl;
  assign fc = bus.link_reset_fastCommand;
  always_comb begin
    stateNext = IDLE;
    burstNext = '0;
    entry = 1'b0;
    emit = 1'b0;
    case (state)
      IDLE: begin
        entry = sc | fc;
        emit = sc | fc;
        stateNext = sc ? SC : fc ? FC : IDLE;
        burstNext = sc ? '0 : fc ? bus.burstLen : '0;
      end
      SC: begin
        emit = sc;
        stateNext = sc ? SC : IDLE;
      end
      FC: begin
        emit = sc | fc | (burstCnt != '0);
        stateNext = sc ? SC : (fc || burstCnt != '0) ? FC : IDLE;
        burstNext = sc ? '0 : fc ? bus.burstLen : burstCnt != '0 ? burstCnt - 1'b1 : '0;
      end
      default: stateNext = IDLE;
    endcase
  end
  // Word 0 is built from the live inputs; later words continue from the registered pattern state.
  always_comb begin
    seed = bus.link_reset_prbs7Seed == 7'd0 ? 7'h7F : bus.link_reset_prbs7Seed;
    curMode = entry ? bus.link_reset_patternMode : mode;
    curPrbs = entry ? seed : prbs;
    curPhase = entry ? '0 : phase;
    curOdd = entry ? 1'b0 : oddWord;
    nxtPrbs = curPrbs;
    nxtPhase = curPhase;
    prbsWord = '0;
    fixedWord = '0;
    for (int i = 0; i < WIDTH; i++) begin
      prbsWord[i] = nxtPrbs[6] ^ nxtPrbs[5];
      nxtPrbs = {nxtPrbs[5:0], prbsWord[i]};
      fixedWord[i] = bus.link_reset_fixedTestPattern[nxtPhase];
      nxtPhase = nxtPhase == PH_W'(FIXED_WIDTH - 1) ? '0 : nxtPhase + 1'b1;
    end
`ifdef LINK_RESET_COUNTER_MODE_EN
    curCnt = entry ? '0 : wordCnt;
    patWord = curMode == 2'b01 ? fixedWord : curMode == 2'b11 ? fixedWord ^ {WIDTH{curOdd}} :
              curMode == 2'b10 ? curCnt : prbsWord;
`else
    patWord = curMode == 2'b01 ? fixedWord : curMode == 2'b11 ? fixedWord ^ {WIDTH{curOdd}} : prbsWord;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.dout <= '0;
      bus.linkResetActive <= 1'b0;
      bus.patternStart <= 1'b0;
      burstCnt <= '0;
      phase <= '0;
      prbs <= 7'h7F;
      mode <= '0;
      oddWord <= 1'b0;
`ifdef LINK_RESET_COUNTER_MODE_EN
      wordCnt <= '0;
`endif
    end else begin
      state <= stateNext;
      burstCnt <= burstNext;
      bus.dout <= emit ? patWord : bus.din;
      bus.linkResetActive <= emit;
      bus.patternStart <= entry;
      if (emit) begin
        mode <= curMode;
        prbs <= nxtPrbs;
        phase <= nxtPhase;
        oddWord <= ~curOdd;
`ifdef LINK_RESET_COUNTER_MODE_EN
        wordCnt <= curCnt + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_link_reset_pattern_gen.sv
// tb_link_reset_pattern_gen: directed + random checks of link_reset_pattern_gen against a stream-level model
module tb_link_reset_pattern_gen;
  localparam int W = 40;
  localparam int FW = 32;
  localparam int BW = 8;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  link_reset_pattern_gen_if #(.WIDTH(W), .FIXED_WIDTH(FW), .BURST_W(BW)) bus();
  link_reset_pattern_gen #(.WIDTH(W), .FIXED_WIDTH(FW), .BURST_W(BW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  bit mActive, mSc;
  int mRem, mK;
  logic [1:0] mMode;
  bit prbsHist[134];
  logic [W-1:0] expDout;
  logic expActive, expStart;
  // PRBS7 stream b[n] = b[n-7] ^ b[n-6]; history slot 7+n holds b[n], and the stream repeats every 127 bits.
  task automatic loadSeed(input logic [6:0] s);
    logic [6:0] e;
    e = (s == 7'd0) ? 7'h7F : s;
    for (int j = 0; j < 7; j++) prbsHist[j] = e[6-j];
    for (int j = 7; j < 134; j++) prbsHist[j] = prbsHist[j-7] ^ prbsHist[j-6];
  endtask
  function automatic logic [W-1:0] patWord(input int k);
    logic [W-1:0] w;
    logic [1:0] m;
    longint n;
    m = mMode;
`ifdef LINK_RESET_COUNTER_MODE_EN
    if (m == 2'b10) return W'(longint'(k));
`else
    if (m == 2'b10) m = 2'b00;
`endif
    for (int i = 0; i < W; i++) begin
      n = longint'(k) * W + i;
      if (m == 2'b00) w[i] = prbsHist[7 + int'(n % 127)];
      else w[i] = bus.link_reset_fixedTestPattern[int'(n % FW)] ^ (m == 2'b11 && (k % 2) == 1);
    end
    return w;
  endfunction
  task automatic modelStep();
    bit sc, fc;
    sc = bus.link_reset_slowControl;
    fc = bus.link_reset_fastCommand;
    expStart = 1'b0;
    if (reset) begin
      mActive = 1'b0;
      expDout = '0;
      expActive = 1'b0;
      return;
    end
    if (!mActive) begin
      if (sc || fc) begin
        mActive = 1'b1;
        mSc = sc;
        mRem = int'(bus.burstLen);
        mK = 0;
        mMode = bus.link_reset_patternMode;
        loadSeed(bus.link_reset_prbs7Seed);
        expStart = 1'b1;
      end
    end else if (mSc) begin
      if (!sc) mActive = 1'b0;
      else mK++;
    end else if (sc) begin
      mSc = 1'b1;
      mK++;
    end else if (fc) begin
      mRem = int'(bus.burstLen);
      mK++;
    end else if (mRem == 0) mActive = 1'b0;
    else begin
      mRem--;
      mK++;
    end
    expActive = mActive;
    expDout = mActive ? patWord(mK) : bus.din;
  endtask
  task automatic tick(input string tag);
    bus.din = W'({$urandom(), $urandom()});
    @(posedge clk);
    #1;
    modelStep();
    checks++;
    assert (bus.dout === expDout) else begin
      errors++;
      $error("FAIL %s dout got %h want %h", tag, bus.dout, expDout);
    end
    checks++;
    assert (bus.linkResetActive === expActive) else begin
      errors++;
      $error("FAIL %s linkResetActive got %b want %b", tag, bus.linkResetActive, expActive);
    end
    checks++;
    assert (bus.patternStart === expStart) else begin
      errors++;
      $error("FAIL %s patternStart got %b want %b", tag, bus.patternStart, expStart);
    end
  endtask
  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask
  initial begin
    reset = 1'b1;
    bus.link_reset_slowControl = 1'b0;
    bus.link_reset_fastCommand = 1'b0;
    bus.link_reset_patternMode = 2'b01;
    bus.link_reset_prbs7Seed = 7'h2A;
    bus.link_reset_fixedTestPattern = 32'h3C5C3C5A;
    bus.burstLen = 8'd4;
    bus.din = '0;
    ticks("reset", 2);
    reset = 1'b0;
    ticks("idle_din", 3);
    bus.link_reset_slowControl = 1'b1;
    ticks("fixed_sc", 3);
    bus.link_reset_slowControl = 1'b0;
    ticks("fixed_exit", 2);
    bus.link_reset_patternMode = 2'b00;
    bus.link_reset_slowControl = 1'b1;
    ticks("prbs_2a", 10);
    bus.link_reset_slowControl = 1'b0;
    ticks("prbs_exit", 2);
    bus.link_reset_prbs7Seed = 7'h00;
    bus.link_reset_slowControl = 1'b1;
    ticks("prbs_seed0", 4);
    bus.link_reset_slowControl = 1'b0;
    tick("prbs_seed0_exit");
    bus.link_reset_patternMode = 2'b10;
    bus.link_reset_prbs7Seed = 7'h15;
    bus.link_reset_fastCommand = 1'b1;
    tick("fc_start");
    bus.link_reset_fastCommand = 1'b0;
    ticks("fc_burst", 6);
    bus.link_reset_fastCommand = 1'b1;
    tick("fc2_start");
    bus.link_reset_fastCommand = 1'b0;
    ticks("fc2_burst", 2);
    bus.link_reset_fastCommand = 1'b1;
    tick("fc2_reload");
    bus.link_reset_fastCommand = 1'b0;
    ticks("fc2_ext", 6);
    bus.link_reset_patternMode = 2'b01;
    bus.link_reset_fastCommand = 1'b1;
    tick("fc_to_sc_start");
    bus.link_reset_fastCommand = 1'b0;
    bus.link_reset_patternMode = 2'b11;
    tick("mode_latched");
    bus.link_reset_slowControl = 1'b1;
    ticks("fc_to_sc", 6);
    bus.link_reset_fastCommand = 1'b1;
    tick("fc_in_sc");
    bus.link_reset_fastCommand = 1'b0;
    bus.link_reset_fixedTestPattern = 32'h12345678;
    ticks("sc_live_fixed", 2);
    bus.link_reset_slowControl = 1'b0;
    ticks("sc_exit", 2);
    bus.link_reset_fixedTestPattern = 32'hAAAAAAAA;
    bus.link_reset_slowControl = 1'b1;
    ticks("alt_aa", 4);
    reset = 1'b1;
    tick("reset_mid_sc");
    reset = 1'b0;
    ticks("sc_after_reset", 3);
    bus.link_reset_slowControl = 1'b0;
    tick("sc_exit2");
    bus.burstLen = 8'd0;
    bus.link_reset_patternMode = 2'b00;
    bus.link_reset_fastCommand = 1'b1;
    tick("burst0");
    bus.link_reset_fastCommand = 1'b0;
    ticks("burst0_end", 3);
    bus.burstLen = 8'hFF;
    bus.link_reset_patternMode = 2'b01;
    bus.link_reset_fastCommand = 1'b1;
    tick("burst256_start");
    bus.link_reset_fastCommand = 1'b0;
    ticks("burst256", 258);
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 11) == 0) bus.link_reset_slowControl = ~bus.link_reset_slowControl;
      bus.link_reset_fastCommand = ($urandom_range(0, 9) == 0);
      bus.link_reset_patternMode = 2'($urandom_range(0, 3));
      bus.link_reset_prbs7Seed = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom());
      if ($urandom_range(0, 15) == 0) bus.link_reset_fixedTestPattern = $urandom();
      bus.burstLen = ($urandom_range(0, 19) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 12));
      tick("random");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/link_reset_pattern_gen.md
LINK_RESET_PATTERN_GEN -- requirements
Module: link_reset_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 40: output word width in bits, range 8..64.
REQ-002 Parameter FIXED_WIDTH, default 32: fixed test pattern width in bits, range 8..64.
REQ-003 Parameter BURST_W, default 8: width of the burst-length field.
REQ-004 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port link_reset_slowControl, input, 1: level request; pattern SHALL be output while it is high.
REQ-007 Port link_reset_fastCommand, input, 1: single-cycle request for a bounded pattern burst.
REQ-008 Port link_reset_patternMode, input, 2: pattern select; 00 PRBS7, 01 fixed, 10 counter, 11 alternating fixed/inverted fixed.
REQ-009 Port link_reset_prbs7Seed, input, 7: PRBS7 seed.
REQ-010 Port link_reset_fixedTestPattern, input, FIXED_WIDTH: fixed pattern.
REQ-011 Port burstLen, input, BURST_W: fast-command burst length; a burst SHALL be burstLen+1 words.
REQ-012 Port din, input, WIDTH: normal readout word.
REQ-013 Port dout, output, WIDTH: registered output word.
REQ-014 Port linkResetActive, output, 1: high while dout carries pattern.
REQ-015 Port patternStart, output, 1: one-cycle pulse coinciding with the first pattern word.

Function
REQ-016 The FSM SHALL have states IDLE, SC (slow-control pattern) and FC (fast-command burst).
REQ-017 In IDLE, dout SHALL equal din delayed by one clk; linkResetActive=0.
REQ-018 Transitions: IDLE->SC when slowControl=1; IDLE->FC when fastCommand=1 and slowControl=0; SC->IDLE when slowControl=0; FC->IDLE after the last burst word; FC->SC when slowControl=1, which abandons the burst.
REQ-019 fastCommand in SC SHALL be ignored.
REQ-020 fastCommand in FC SHALL reload the burst counter to burstLen without restarting pattern state; patternStart SHALL NOT pulse.
REQ-021 The first pattern word SHALL appear on dout one clk after the request is sampled; patternStart=1 on that word only.
REQ-022 link_reset_patternMode SHALL be latched on entry to SC/FC (from IDLE) and held until return to IDLE; prbs7Seed SHALL be latched at the same time.
REQ-023 link_reset_fixedTestPattern SHALL be sampled live every cycle.
REQ-024 PRBS7: polynomial x^7+x^6+1, advancing WIDTH bits per clk, dout[0] first in time. A latched seed of 0 SHALL be replaced by 7'h7F.
REQ-025 Fixed: dout bit i of pattern word k SHALL equal pattern bit ((k*WIDTH+i) mod FIXED_WIDTH). A phase register SHALL carry the offset across words and reset to 0 on pattern entry.
REQ-026 Alternating: the fixed-pattern word SHALL be XORed with all-ones on odd pattern words (k odd).
REQ-027 Counter: pattern word k SHALL equal k mod 2^WIDTH, wrapping to 0.
REQ-028 On return to IDLE, dout SHALL resume din on the next clk with no gap word; linkResetActive SHALL fall with it.
REQ-029 burstLen=0 SHALL produce exactly one pattern word; burstLen=2^BURST_W-1 SHALL produce 2^BURST_W words.

Reset
REQ-030 While reset=1: state IDLE, dout=0, linkResetActive=0, patternStart=0, burst counter=0, phase=0, PRBS register=7'h7F.
REQ-031 Reset asserted mid-pattern SHALL abort on the same edge. After release, a still-high slowControl SHALL re-enter SC with patternStart.

Configuration
REQ-032 Macro LINK_RESET_COUNTER_MODE_EN: when defined, mode 10 SHALL be the counter pattern. When undefined, the counter logic SHALL be absent and mode 10 SHALL behave as mode 00 (PRBS7).

Verification
REQ-033 WIDTH=40, fixed=32'h3C5C3C5A, mode 01, slowControl held 3 cycles -> three words with phases 0/8/16, patternStart on the first word only.
REQ-034 Mode 00, seed 7'h2A, slowControl held 10 cycles -> dout matches the PRBS7 reference model bit-exactly. Seed 0 -> sequence starts from 7'h7F.
REQ-035 fastCommand with burstLen=4, mode 10 -> dout 0,1,2,3,4 then din. A second fastCommand at word 2 -> burst extended to 0..7, single patternStart.
REQ-036 slowControl rising during an FC burst -> burst abandoned, pattern continues uninterrupted under SC; fastCommand during SC -> no effect.
REQ-037 Mode 11 with fixed=32'hAAAAAAAA, WIDTH=32 -> AAAAAAAA, 55555555, AAAAAAAA alternating.
REQ-038 reset asserted during SC -> dout=0 the next cycle; with macro undefined, mode 10 -> output identical to mode 00.
